mux2x1_rr_arbiter: RTL and testbench
====================================

Name: mux2x1_rr_arbiter

Overview:
Round-robin arbiter and sequencer for a shared 2:1 datapath mux. Two requester channels, A and B, each use valid/ready handshakes, and their beats are steered onto one registered output channel. The mux select is driven internally and exported as y_src, with the same encoding as the mux select: 0 = A, 1 = B. Bursts are bounded by MAX_BURST so neither requester can starve the other.

Parameters:
WIDTH, 8, data width of each channel.
MAX_BURST, 4, maximum consecutive beats granted to one requester while the other is waiting (must be >= 1).

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-high.
a_valid  input  1  requester A has a beat.
a_data  input  WIDTH  requester A payload.
a_ready  output  1  A beat accepted this cycle when a_valid && a_ready.
b_valid  input  1  requester B has a beat.
b_data  input  WIDTH  requester B payload.
b_ready  output  1  B beat accepted this cycle when b_valid && b_ready.
y_valid  output  1  output beat present (registered).
y_data  output  WIDTH  output payload (registered).
y_src  output  1  source of the current output beat: 0 = A, 1 = B (registered).
y_ready  input  1  downstream accepts the output beat.

Behaviour:
- Internal state:
  - state: IDLE / GRANT_A / GRANT_B.
  - burst_cnt: width $clog2(MAX_BURST+1).
  - last: most recently served requester.
- slot_free = !y_valid || y_ready.
- Selection (combinational, every cycle):
  - If state is GRANT_X, X_valid, and burst_cnt < MAX_BURST: sel = X (continue the burst).
  - Otherwise, if only one requester is valid: sel = that one.
  - Otherwise, if both are valid: sel = !last (round-robin).
  - If neither is valid: no selection.
- Ready outputs:
  - a_ready = slot_free && selection exists && sel==A.
  - b_ready = slot_free && selection exists && sel==B.
  - At most one ready is high in any cycle.
  - Both readies are 0 while rst is high.
- Transfer (slot_free and a selection exists):
  - y_data <= X_data, y_src <= X, y_valid <= 1, last <= X, state <= GRANT_X.
  - burst_cnt <= burst_cnt+1 if the burst continues; otherwise 1.
  - A burst restarts at 1 on a requester switch, or when burst_cnt == MAX_BURST and the other requester is idle. In the second case the same requester keeps the grant with a fresh burst.
- slot_free with no valid requester:
  - y_valid <= 0, state <= IDLE, burst_cnt <= 0.
  - last is unchanged.
- Backpressure (!slot_free):
  - y_valid, y_data and y_src are held stable.
  - Both readies are 0.
  - state, burst_cnt and last are frozen.
- Latency: input accept to y_valid is 1 cycle. Throughput is 1 beat/cycle with y_ready held high; no bubbles on a requester switch.
- Requester drops valid mid-burst: its grant is released immediately. The other requester, if valid, is granted the same cycle with burst_cnt restarting at 1.
- Reset values:
  - y_valid=0, y_data=0, y_src=0.
  - state=IDLE, burst_cnt=0, last=1, so A wins the first tie.
- Reset asserted mid-operation: a buffered beat is discarded (y_valid=0 on the cycle after the rst edge). No input beat is accepted while rst is high.
- Data is never duplicated or dropped outside reset. Every accepted beat appears exactly once on y, in acceptance order.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0 and y_valid=0 throughout. Deassert with both still valid -> A accepted on the first cycle, and y_src=0 one cycle later.
2. A-only stream: a_data 0x10..0x15 on consecutive cycles, b_valid=0, y_ready=1 -> y_data is 0x10..0x15, each one cycle after accept, y_src=0, y_valid continuous. A continues past MAX_BURST with no gap.
3. Both valid continuously, y_ready=1, MAX_BURST=4 -> y_src sequence is 0,0,0,0,1,1,1,1,0,0,0,0 with no idle cycles.
4. Backpressure: y_valid=1 with y_data=0x21, then y_ready=0 for 3 cycles -> y_data stays 0x21, a_ready=b_ready=0, burst_cnt is unchanged. Raise y_ready -> the next beat follows the next cycle and the burst count resumes.
5. Both valid; A drops a_valid after 2 beats -> B granted the same cycle. B gets a full 4-beat burst, then A regains the grant if valid.
6. Reset mid-burst (A at beat 3, y_valid=1) -> y_valid=0 the cycle after the rst edge. After release with both valid, A is granted first with burst_cnt=1.

Source files
------------

// File: rtl/mux2x1_rr_arbiter.sv
// Purpose: round-robin arbiter that steers requester A or B onto one registered output, with bursts bounded by MAX_BURST.
// Latency: an input beat is accepted and appears on y one cycle later; throughput is 1 beat/cycle with no bubble on a switch.
// Backpressure: while y holds a beat and y_ready is low, both readies drop and all arbitration state is frozen.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   a_valid/a_data/a_ready       requester A handshake
//   b_valid/b_data/b_ready       requester B handshake
//   y_valid/y_data/y_src/y_ready registered output beat, its source (0 = A, 1 = B) and downstream ready
module mux2x1_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_src,
    input  logic             y_ready
);

    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     burst_cnt, cnt_d;
    logic              last, last_d;
    logic              y_valid_d, y_src_d;
    logic [WIDTH-1:0]  y_data_d;

    logic              sel_vld;   // some requester is selected this cycle
    logic              sel;       // 0 = A, 1 = B
    logic              cont;      // selection extends the current burst
    logic              slot_free;

    assign slot_free = !y_valid || y_ready;

    // The current holder keeps the grant until it drops valid or exhausts its
    // burst; after that, a lone requester wins, and a tie goes to whoever was
    // not served last.
    always_comb begin
        sel_vld = 1'b0;
        sel     = 1'b0;
        cont    = 1'b0;
        if (state_q == GRANT_A && a_valid && burst_cnt < MAX_CNT) begin
            sel_vld = 1'b1;
            sel     = 1'b0;
            cont    = 1'b1;
        end else if (state_q == GRANT_B && b_valid && burst_cnt < MAX_CNT) begin
            sel_vld = 1'b1;
            sel     = 1'b1;
            cont    = 1'b1;
        end else if (a_valid && b_valid) begin
            sel_vld = 1'b1;
            sel     = !last;
        end else if (a_valid) begin
            sel_vld = 1'b1;
            sel     = 1'b0;
        end else if (b_valid) begin
            sel_vld = 1'b1;
            sel     = 1'b1;
        end
    end

    assign a_ready = !rst && slot_free && sel_vld && !sel;
    assign b_ready = !rst && slot_free && sel_vld &&  sel;

    // Next-state and output-register logic; nothing moves unless the slot is free.
    always_comb begin
        state_d   = state_q;
        cnt_d     = burst_cnt;
        last_d    = last;
        y_valid_d = y_valid;
        y_data_d  = y_data;
        y_src_d   = y_src;
        if (slot_free) begin
            if (sel_vld) begin
                y_valid_d = 1'b1;
                y_data_d  = sel ? b_data : a_data;
                y_src_d   = sel;
                last_d    = sel;
                state_d   = sel ? GRANT_B : GRANT_A;
                // A switch, or a same-requester regrant after a full burst,
                // starts a fresh burst.
                cnt_d     = cont ? burst_cnt + ONE : ONE;
            end else begin
                y_valid_d = 1'b0;
                state_d   = IDLE;
                cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            burst_cnt <= '0;
            last      <= 1'b1;   // makes A win the first tie after reset
            y_valid   <= 1'b0;
            y_data    <= '0;
            y_src     <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_cnt <= cnt_d;
            last      <= last_d;
            y_valid   <= y_valid_d;
            y_data    <= y_data_d;
            y_src     <= y_src_d;
        end
    end

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Purpose: directed self-checking bench for mux2x1_rr_arbiter (WIDTH=8, MAX_BURST=4).
// Latency: inputs are driven 1 ns after a rising edge; registered outputs are checked then too.
// Backpressure: exercised by holding y_ready low for three cycles with a beat buffered.
module tb_mux2x1_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready;
    logic       y_valid;
    logic [7:0] y_data;
    logic       y_src;
    logic       y_ready;

    int n_chk  = 0;
    int n_pass = 0;

    mux2x1_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_src   (y_src),
        .y_ready (y_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational readies settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        logic [11:0] src3;
        logic [6:0]  src5;
        logic [6:0]  av5;
        logic [4:0]  src6;
        logic        e;

        src3 = 12'b0000_1111_0000;   // bit i = expected y_src of beat i
        src5 = 7'b0111100;
        av5  = 7'b1111011;
        src6 = 5'b10000;

        rst     = 1'b1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'h01;
        b_data  = 8'h02;
        y_ready = 1'b1;

        // 1. Reset held with both requesters valid.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk1($sformatf("rst_a_ready[%0d]", i), a_ready, 1'b0);
            chk1($sformatf("rst_b_ready[%0d]", i), b_ready, 1'b0);
            chk1($sformatf("rst_y_valid[%0d]", i), y_valid, 1'b0);
            chk8($sformatf("rst_y_data[%0d]", i),  y_data,  8'h00);
        end
        rst = 1'b0;
        settle();
        chk1("rel_a_ready", a_ready, 1'b1);
        chk1("rel_b_ready", b_ready, 1'b0);
        tick();
        chk1("rel_y_valid", y_valid, 1'b1);
        chk1("rel_y_src",   y_src,   1'b0);
        chk8("rel_y_data",  y_data,  8'h01);
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        chk1("rel_drain", y_valid, 1'b0);

        // 2. A-only stream runs past MAX_BURST without a gap.
        for (int i = 0; i < 6; i++) begin
            a_valid = 1'b1;
            a_data  = 8'(8'h10 + i);
            settle();
            chk1($sformatf("t2_a_ready[%0d]", i), a_ready, 1'b1);
            tick();
            chk1($sformatf("t2_y_valid[%0d]", i), y_valid, 1'b1);
            chk8($sformatf("t2_y_data[%0d]", i),  y_data,  8'(8'h10 + i));
            chk1($sformatf("t2_y_src[%0d]", i),   y_src,   1'b0);
        end
        a_valid = 1'b0;
        tick();
        chk1("t2_drain", y_valid, 1'b0);

        // 3. Fresh reset so A wins the tie, then both valid continuously.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            a_valid = 1'b1;
            b_valid = 1'b1;
            a_data  = 8'(8'hA0 + i);
            b_data  = 8'(8'hB0 + i);
            tick();
            e = src3[i];
            chk1($sformatf("t3_y_valid[%0d]", i), y_valid, 1'b1);
            chk1($sformatf("t3_y_src[%0d]", i),   y_src,   e);
            chk8($sformatf("t3_y_data[%0d]", i),  y_data,  e ? 8'(8'hB0 + i) : 8'(8'hA0 + i));
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        chk1("t3_drain", y_valid, 1'b0);

        // 4. Backpressure holds the beat and freezes the burst count.
        a_valid = 1'b1;
        a_data  = 8'h21;
        tick();
        chk8("t4_first", y_data, 8'h21);
        y_ready = 1'b0;
        a_data  = 8'h22;
        b_valid = 1'b1;
        b_data  = 8'h31;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk1($sformatf("t4_bp_a_ready[%0d]", i), a_ready, 1'b0);
            chk1($sformatf("t4_bp_b_ready[%0d]", i), b_ready, 1'b0);
            tick();
            chk1($sformatf("t4_bp_y_valid[%0d]", i), y_valid, 1'b1);
            chk8($sformatf("t4_bp_y_data[%0d]", i),  y_data,  8'h21);
        end
        y_ready = 1'b1;
        // A had one beat before the stall, so it gets three more, then B.
        for (int i = 0; i < 4; i++) begin
            a_data = 8'(8'h22 + i);
            tick();
            e = (i == 3);
            chk1($sformatf("t4_y_src[%0d]", i),  y_src,  e);
            chk8($sformatf("t4_y_data[%0d]", i), y_data, e ? 8'h31 : 8'(8'h22 + i));
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();
        chk1("t4_drain", y_valid, 1'b0);

        // 5. A drops valid mid-burst; B takes over the same cycle for a full burst.
        for (int i = 0; i < 7; i++) begin
            a_valid = av5[i];
            b_valid = 1'b1;
            a_data  = 8'(8'h50 + i);
            b_data  = 8'(8'h60 + i);
            e = src5[i];
            settle();
            chk1($sformatf("t5_a_ready[%0d]", i), a_ready, !e);
            chk1($sformatf("t5_b_ready[%0d]", i), b_ready, e);
            tick();
            chk1($sformatf("t5_y_src[%0d]", i),  y_src,  e);
            chk8($sformatf("t5_y_data[%0d]", i), y_data, e ? 8'(8'h60 + i) : 8'(8'h50 + i));
        end

        // 6. A continues alone to beat 3, then reset mid-burst.
        b_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_data = 8'(8'h70 + i);
            tick();
            chk8($sformatf("t6_pre_y_data[%0d]", i), y_data, 8'(8'h70 + i));
        end
        chk1("t6_pre_y_valid", y_valid, 1'b1);
        rst     = 1'b1;
        b_valid = 1'b1;
        settle();
        chk1("t6_rst_a_ready", a_ready, 1'b0);
        chk1("t6_rst_b_ready", b_ready, 1'b0);
        tick();
        chk1("t6_rst_y_valid", y_valid, 1'b0);
        rst = 1'b0;
        // Fresh burst after reset: A for four beats, then B.
        for (int i = 0; i < 5; i++) begin
            a_data = 8'(8'h80 + i);
            b_data = 8'(8'h90 + i);
            e = src6[i];
            settle();
            chk1($sformatf("t6_a_ready[%0d]", i), a_ready, !e);
            tick();
            chk1($sformatf("t6_y_src[%0d]", i),  y_src,  e);
            chk8($sformatf("t6_y_data[%0d]", i), y_data, e ? 8'(8'h90 + i) : 8'(8'h80 + i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
